seven_seg_capture: RTL

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_capture.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers hex digits from a scanned, active-low
// seven-segment display bus once each display state has settled.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   an[3:0]    in   anode bus, active-low, an[0] = rightmost digit
//   seg[6:0]   in   segment bus, active-low, seg[0]=a .. seg[6]=g
//   digits     out  captured nibbles, digits[4i+3:4i] belongs to an[i]
//   valid      out  valid[i] set while nibble i holds a good capture
//   frame_done out  one-cycle pulse when all four digits were seen
//   err        out  sticky flag for illegal anode/segment captures

module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        err
);

    localparam logic [7:0] FULL = 8'(SETTLE_CYCLES);
    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [10:0] IDLE = 11'h7FF;

    logic [10:0] sample;
    logic [7:0]  count;
    logic [3:0]  seen;

    logic        same;
    logic        capture;
    logic        blank;
    logic        one_low;
    logic [1:0]  sel;
    logic        legal;
    logic [3:0]  hex;

    assign same    = ({an, seg} == sample);
    // Fires on the edge where the stable run reaches SETTLE_CYCLES.
    assign capture = same && (count == LAST);
    assign blank   = (an == 4'b1111);

    always_comb begin
        one_low = 1'b1;
        sel     = 2'd0;
        case (an)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        hex   = 4'h0;
        case (seg)
            7'b1000000: hex = 4'h0;
            7'b1111001: hex = 4'h1;
            7'b0100100: hex = 4'h2;
            7'b0110000: hex = 4'h3;
            7'b0011001: hex = 4'h4;
            7'b0010010: hex = 4'h5;
            7'b0000010: hex = 4'h6;
            7'b1111000: hex = 4'h7;
            7'b0000000: hex = 4'h8;
            7'b0010000: hex = 4'h9;
            7'b0001000: hex = 4'hA;
            7'b0000011: hex = 4'hB;
            7'b1000110: hex = 4'hC;
            7'b0100001: hex = 4'hD;
            7'b0000110: hex = 4'hE;
            7'b0001110: hex = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample     <= IDLE;
            count      <= 8'd0;
            seen       <= 4'b0000;
            digits     <= 16'h0000;
            valid      <= 4'b0000;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            sample     <= {an, seg};
            frame_done <= 1'b0;

            if (!same) begin
                count <= 8'd0;
            end else if (count < FULL) begin
                count <= count + 8'd1;
            end

            if (capture && !blank) begin
                if (one_low) begin
                    if (legal) begin
                        digits[{sel, 2'b00} +: 4] <= hex;
                        valid[sel] <= 1'b1;
                        // Completing the mask closes the frame.
                        if ((seen | ~an) == 4'b1111) begin
                            frame_done <= 1'b1;
                            seen       <= 4'b0000;
                        end else begin
                            seen <= seen | ~an;
                        end
                    end else begin
                        valid[sel] <= 1'b0;
                        err        <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
